// File: rtl/memory_bank.sv
// Byte-addressed memory bank with configurable response latency.
// Little-endian byte/half/word access, alignment faults, single outstanding request.
module memory_bank #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] data_in,
  input  logic        memory_read_en,
  input  logic        memory_write_en,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT =
    (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [7:0]  r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic        r_fault;

  logic          w_accept;
  logic          w_bad;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [7:0]    w_b3;
  logic [31:0]   w_rword;
  logic          w_unused;

  // Upper address bits select nothing: the bank wraps.
  assign w_unused = &{1'b0, addr[31:AW]};
  assign w_idx    = addr[AW-1:0];

  assign w_accept = (r_state != WAIT) &&
                    (memory_read_en || memory_write_en);
  assign w_wr     = w_accept && !memory_read_en && !w_bad;

  assign w_b0 = r_mem[w_idx];
  assign w_b1 = r_mem[w_idx + AW'(1)];
  assign w_b2 = r_mem[w_idx + AW'(2)];
  assign w_b3 = r_mem[w_idx + AW'(3)];

  always_comb begin
    w_bad = 1'b0;
    unique case (size)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = addr[0];
      2'b10:   w_bad = |addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_rword = '0;
    unique case (size)
      2'b00:   w_rword = {24'h0, w_b0};
      2'b01:   w_rword = {16'h0, w_b1, w_b0};
      2'b10:   w_rword = {w_b3, w_b2, w_b1, w_b0};
      default: w_rword = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= CNT_INIT;
      else if (r_state == WAIT && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, RESP: begin
        if (w_accept)
          w_next = (LATENCY == 1) ? RESP : WAIT;
        else
          w_next = IDLE;
      end
      WAIT: begin
        if (r_cnt == 3'd0)
          w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = (r_state == RESP);
    busy     = (r_state == WAIT);
    data_out = ready ? r_rdata : 32'h0;
    fault    = ready ? r_fault : 1'b0;
  end

  // Response is frozen at acceptance; later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_bad;
      r_rdata <= (memory_read_en && !w_bad) ? w_rword : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      unique case (size)
        2'b00: r_mem[w_idx] <= data_in[7:0];
        2'b01: begin
          r_mem[w_idx]          <= data_in[7:0];
          r_mem[w_idx + AW'(1)] <= data_in[15:8];
        end
        2'b10: begin
          r_mem[w_idx]          <= data_in[7:0];
          r_mem[w_idx + AW'(1)] <= data_in[15:8];
          r_mem[w_idx + AW'(2)] <= data_in[23:16];
          r_mem[w_idx + AW'(3)] <= data_in[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// Bench for memory_bank: two instances (LATENCY 1 and 3) share stimulus
// and are checked against a byte-array reference model.
module tb_memory_bank;

  localparam int DEP = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] data_in;
  logic        rd_en;
  logic        wr_en;

  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        flt  [2];
  logic        bsy  [2];

  int lat [2] = '{1, 3};

  logic [7:0] mem_m [DEP];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_bank #(.DEPTH(DEP), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .addr(addr), .size(size),
    .data_in(data_in), .memory_read_en(rd_en),
    .memory_write_en(wr_en), .data_out(dout[0]),
    .ready(rdy[0]), .fault(flt[0]), .busy(bsy[0])
  );

  memory_bank #(.DEPTH(DEP), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .addr(addr), .size(size),
    .data_in(data_in), .memory_read_en(rd_en),
    .memory_write_en(wr_en), .data_out(dout[1]),
    .ready(rdy[1]), .fault(flt[1]), .busy(bsy[1])
  );

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_fault(
    input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] model_read(
    input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(s); i++)
      v = v | (32'(mem_m[(a + 32'(i)) % 32'(DEP)]) << (8 * i));
    return v;
  endfunction

  function automatic void model_write(
    input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++)
      mem_m[(a + 32'(i)) % 32'(DEP)] = d[8*i +: 8];
  endfunction

  task automatic scramble();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = $urandom;
    size    = 2'($urandom);
    data_in = $urandom;
  endtask

  // One isolated transaction; both instances are idle when it is issued.
  task automatic do_req(input logic r, input logic w,
                        input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, input string tag);
    logic        f;
    logic [31:0] exp;
    logic [34:0] got;
    logic [34:0] want;
    f   = model_fault(a, s);
    exp = (r && !f) ? model_read(a, s) : 32'h0;
    @(negedge clk);
    rd_en = r; wr_en = w; addr = a; size = s; data_in = d;
    @(posedge clk);
    if (w && !r && !f) model_write(a, s, d);
    #1 scramble();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        want = (c == lat[k]) ? {1'b1, 1'b0, f, exp}
                             : {1'b0, c < lat[k], 1'b0, 32'h0};
        got  = {rdy[k], bsy[k], flt[k], dout[k]};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d got=%h want=%h",
                   tag, k, c, got, want);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b1;
    addr = 32'h4; size = 2'd2; data_in = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rdy[k], bsy[k], flt[k], dout[k]} !== 35'h0) begin
        bad++;
        $display("FAIL reset dut%0d got=%h want=0", k,
                 {rdy[k], bsy[k], flt[k], dout[k]});
      end
    end
    rst = 1'b0;
    scramble();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEP / 4; i++)
      do_req(1'b0, 1'b1, 32'(i * 4), 2'd2, $urandom, "fill");
  endtask

  task automatic test_directed();
    do_req(1'b0, 1'b1, 32'h10, 2'd2, 32'hDDCC_BBAA, "wr_word10");
    do_req(1'b1, 1'b0, 32'h12, 2'd0, 32'h0, "rd_byte12");
    total++;
    if (model_read(32'h12, 2'd0) !== 32'hCC) begin
      bad++;
      $display("FAIL model_byte12 got=%h want=cc",
               model_read(32'h12, 2'd0));
    end
    do_req(1'b1, 1'b0, 32'h10, 2'd1, 32'h0, "rd_half10");
    do_req(1'b0, 1'b1, 32'h0000_0105, 2'd0, 32'h5A, "wr_wrap");
    do_req(1'b1, 1'b0, 32'h05, 2'd0, 32'h0, "rd_wrap");
    do_req(1'b0, 1'b1, 32'h21, 2'd1, 32'hBEEF, "wr_half_mis");
    do_req(1'b1, 1'b0, 32'h20, 2'd3, 32'h0, "rd_size3");
    do_req(1'b1, 1'b0, 32'h20, 2'd2, 32'h0, "rd_word20");
    do_req(1'b1, 1'b0, 32'h22, 2'd2, 32'h0, "rd_word_mis");
    do_req(1'b1, 1'b1, 32'h30, 2'd0, 32'hFF, "both_en");
    do_req(1'b1, 1'b0, 32'h30, 2'd0, 32'h0, "rd_byte30");
  endtask

  task automatic test_random();
    logic r;
    logic w;
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      do_req(r, w, $urandom, 2'($urandom), $urandom, "rand");
    end
  endtask

  // Request B is held from the cycle after A is accepted until both take it.
  task automatic test_back_to_back();
    logic [31:0] a_ad;
    logic [31:0] b_ad;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [34:0] want [2];
    logic [34:0] got;
    a_ad = $urandom & 32'hFFFF_FFFC;
    b_ad = $urandom & 32'hFFFF_FFFC;
    ea   = model_read(a_ad, 2'd2);
    eb   = model_read(b_ad, 2'd2);
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; size = 2'd2; addr = a_ad;
    @(posedge clk);
    #1 addr = b_ad;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      want[0] = (c <= 4) ? {3'b100, (c == 1) ? ea : eb} : 35'h0;
      want[1] = (c == 3) ? {3'b100, ea} :
                (c == 6) ? {3'b100, eb} :
                {1'b0, c != 3 && c != 6, 1'b0, 32'h0};
      for (int k = 0; k < 2; k++) begin
        got = {rdy[k], bsy[k], flt[k], dout[k]};
        total++;
        if (got !== want[k]) begin
          bad++;
          $display("FAIL b2b dut%0d cyc=%0d got=%h want=%h",
                   k, c, got, want[k]);
        end
      end
      if (c == 3) begin
        @(posedge clk);
        #1 scramble();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [31:0] w;
    logic [34:0] want [2];
    logic [34:0] got;
    a = $urandom & 32'hFFFF_FFFC;
    w = $urandom;
    do_req(1'b0, 1'b1, a, 2'd2, w, "pre_rst_wr");
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; addr = a; size = 2'd2;
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b1; data_in = ~w; rst = 1'b1;
    @(negedge clk);
    want[0] = {3'b100, w};
    want[1] = {3'b010, 32'h0};
    for (int k = 0; k < 2; k++) begin
      got = {rdy[k], bsy[k], flt[k], dout[k]};
      total++;
      if (got !== want[k]) begin
        bad++;
        $display("FAIL rst_mid_pre dut%0d got=%h want=%h",
                 k, got, want[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    scramble();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        got = {rdy[k], bsy[k], flt[k], dout[k]};
        total++;
        if (got !== 35'h0) begin
          bad++;
          $display("FAIL rst_mid dut%0d cyc=%0d got=%h want=0",
                   k, c, got);
        end
      end
    end
    do_req(1'b1, 1'b0, a, 2'd2, 32'h0, "post_rst_rd");
  endtask

  initial begin
    rst = 1'b1;
    scramble();
    test_reset();
    test_fill();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bank.md
MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 256: byte capacity, power of two, 4..65536.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request acceptance to response, 1..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port addr  input  32  byte address.
REQ-006 SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port data_in  input  32  write data, little-endian, low bytes used for byte/half.
REQ-008 SHALL have port memory_read_en  input  1  read request.
REQ-009 SHALL have port memory_write_en  input  1  write request.
REQ-010 SHALL have port data_out  output  32  read data, zero-extended.
REQ-011 SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port fault  output  1  error flag, valid only with ready.
REQ-013 SHALL have port busy  output  1  high while a request is pending and no new request is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; busy = (state == WAIT).
REQ-015 SHALL accept a request at a rising edge when state is IDLE or RESP and memory_read_en or memory_write_en is high.
REQ-016 SHALL treat both enables high as a read; the write is discarded.
REQ-017 SHALL ignore requests while in WAIT; requesters hold the request until busy is low.
REQ-018 SHALL, on acceptance, go to RESP if LATENCY == 1, else to WAIT with counter loaded to LATENCY-2.
REQ-019 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where it is 0.
REQ-020 SHALL, in RESP with no new request, return to IDLE on the next edge.
REQ-021 SHALL drive ready high for exactly one cycle per accepted request, LATENCY cycles after the accepting edge; ready is high only in RESP.
REQ-022 SHALL form the byte index as addr mod DEPTH; upper address bits are ignored (wrap-around).
REQ-023 SHALL assemble multi-byte accesses little-endian: byte at index i is bits 7:0.
REQ-024 SHALL flag fault for size 11, for halfword with addr[0] = 1, and for word with addr[1:0] != 00.
REQ-025 SHALL, on a faulting request, leave memory unchanged, drive data_out = 0, and assert fault with ready.
REQ-026 SHALL commit a legal write to memory at the accepting edge.
REQ-027 SHALL capture read data at the accepting edge and hold it in a response register until ready; later writes do not alter it.
REQ-028 SHALL acknowledge writes with ready, fault = 0 and data_out = 0.
REQ-029 SHALL hold data_out and fault at 0 in cycles where ready is low.
REQ-030 SHALL sustain one request per cycle with LATENCY == 1 and one per LATENCY cycles otherwise.

Reset
REQ-031 SHALL, while rst is high at an edge, force state IDLE, counter 0, ready 0, fault 0, busy 0, data_out 0.
REQ-032 SHALL give rst priority over request acceptance in the same cycle.
REQ-033 SHALL drop a pending response when rst is asserted mid-operation: no ready is issued for it.
REQ-034 SHALL keep a write that was already committed before reset.
REQ-035 SHALL NOT clear memory contents on reset.

Verification
REQ-036 LATENCY=1: write word 0xDDCCBBAA at 0x10, then read byte 0x12 -> ready one cycle after each accept; read data_out = 0x000000CC, fault = 0.
REQ-037 LATENCY=3: read issued at edge k -> busy high for 2 cycles; ready high in the cycle after edge k+2; request presented during busy is accepted only after busy falls.
REQ-038 DEPTH=256: write byte 0x5A at addr 0x0000_0105, then read byte at 0x05 -> data_out = 0x0000005A (wrap).
REQ-039 Halfword write at 0x21 and size=11 read -> ready with fault = 1, data_out = 0; memory at 0x20..0x23 unchanged.
REQ-040 Both enables high at addr 0x30 with data_in 0xFF -> read response returned; byte 0x30 unchanged.
REQ-041 LATENCY=4: rst asserted two cycles after a read is accepted -> no ready, busy = 0 next cycle; a new read at the next edge returns correct data.
